// File: rtl/p405s_itlb_pkg.sv
// p405s_itlb_pkg: shared state encoding, size defaults and index-width helper
// for the shadow-ITLB miss controller.
package p405s_itlb_pkg;

    localparam int NUM_ENTRIES_DEF = 4;
    localparam int EPN_W_DEF       = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } itlb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p405s_itlb_hit_enc.sv
// p405s_itlb_hit_enc: lowest-index priority encoder over the per-entry hits,
// with a flag when more than one entry hits.
module p405s_itlb_hit_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     hit_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             multi_o
);

    logic seen;

    assign any_o = |hit_i;

    always_comb begin
        idx_o   = '0;
        multi_o = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hit_i[i]) begin
                multi_o = multi_o | seen;
                idx_o   = seen ? idx_o : IDX_W'(i);
                seen    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p405s_itlb_miss_ctl.sv
// p405s_itlb_miss_ctl: shadow-ITLB hit encode and miss sequencer (UTLB request,
// response wait, round-robin shadow fill). Optional P405S_ITLB_MULTIHIT_DET_EN.
module p405s_itlb_miss_ctl
    import p405s_itlb_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int EPN_W       = EPN_W_DEF,
    parameter int IDX_W       = idx_w(NUM_ENTRIES)
) (
    input  logic                   CB,
    input  logic                   Reset,
    input  logic [NUM_ENTRIES-1:0] entryHit,
    input  logic                   isFetchVal,
    input  logic                   msrIrL2,
    input  logic                   isAbort,
    input  logic [EPN_W-1:0]       isEA,
    input  logic                   utlbGnt,
    input  logic                   utlbAck,
    input  logic                   utlbMiss,
    output logic                   itlbHit,
    output logic [IDX_W-1:0]       itlbHitIdx,
    output logic                   isStall,
    output logic                   utlbReq,
    output logic [EPN_W-1:0]       utlbReqEA,
    output logic                   writeShadow,
    output logic [IDX_W-1:0]       writeIdx,
    output logic                   itlbMissExc,
    output logic                   itlbMultiHit
);

    itlb_state_e      state_q;
    logic             req_q, drop_q, ws_q, exc_q, mh_q, ovr_q;
    logic [IDX_W-1:0] victim_q, fill_q;
    logic [EPN_W-1:0] ea_q;
    logic             hit_any, hit_multi, qual, miss, ovr_det, mh_det;
    logic [IDX_W-1:0] hit_idx;

    p405s_itlb_hit_enc #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_enc (
        .hit_i   (entryHit),
        .any_o   (hit_any),
        .idx_o   (hit_idx),
        .multi_o (hit_multi)
    );

    assign qual = isFetchVal & msrIrL2;

`ifdef P405S_ITLB_MULTIHIT_DET_EN
    // A multi-hit is refetched through the UTLB and refilled into the lowest hitter.
    assign itlbHit = qual & hit_any & ~hit_multi;
    assign miss    = qual & (~hit_any | hit_multi) & ~isAbort;
    assign ovr_det = hit_multi;
    assign mh_det  = (state_q == IDLE) & qual & hit_multi;
`else
    logic unused_multi;
    assign unused_multi = hit_multi;
    assign itlbHit      = qual & hit_any;
    assign miss         = qual & ~hit_any & ~isAbort;
    assign ovr_det      = 1'b0;
    assign mh_det       = 1'b0;
`endif

    assign itlbHitIdx   = hit_idx;
    assign isStall      = (state_q == IDLE) ? miss : 1'b1;
    assign utlbReq      = req_q;
    assign utlbReqEA    = ea_q;
    assign writeShadow  = ws_q;
    assign writeIdx     = ovr_q ? fill_q : victim_q;
    assign itlbMissExc  = exc_q;
    assign itlbMultiHit = mh_q;

    always_ff @(posedge CB or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
            ws_q     <= 1'b0;
            exc_q    <= 1'b0;
            mh_q     <= 1'b0;
            ovr_q    <= 1'b0;
            victim_q <= '0;
            fill_q   <= '0;
            ea_q     <= '0;
        end else begin
            ws_q  <= 1'b0;
            exc_q <= 1'b0;
            mh_q  <= mh_det;
            case (state_q)
                IDLE: if (miss) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    ea_q    <= isEA;
                    ovr_q   <= ovr_det;
                    fill_q  <= hit_idx;
                end
                REQ: if (utlbGnt) begin
                    // A grant racing an abort still owes us a response; drop it later.
                    state_q <= WAIT;
                    req_q   <= 1'b0;
                    drop_q  <= isAbort;
                end else if (isAbort) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
                WAIT: if (utlbAck) begin
                    drop_q <= 1'b0;
                    if (drop_q | isAbort) begin
                        state_q <= IDLE;
                    end else if (utlbMiss) begin
                        state_q <= IDLE;
                        exc_q   <= 1'b1;
                    end else begin
                        state_q <= FILL;
                        ws_q    <= 1'b1;
                    end
                end else if (isAbort) begin
                    drop_q <= 1'b1;
                end
                FILL: begin
                    state_q <= IDLE;
                    ovr_q   <= 1'b0;
                    if (!ovr_q) victim_q <= victim_q + IDX_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_itlb_miss_ctl.sv
// tb_p405s_itlb_miss_ctl: directed vectors for hit encode plus hand-written
// miss, abort, reset and multi-hit sequences.
module tb_p405s_itlb_miss_ctl;

    logic        CB = 1'b0, Reset = 1'b1;
    logic [3:0]  entryHit = '0;
    logic        isFetchVal = 1'b0, msrIrL2 = 1'b1, isAbort = 1'b0;
    logic [21:0] isEA = '0;
    logic        utlbGnt = 1'b0, utlbAck = 1'b0, utlbMiss = 1'b0;
    logic        itlbHit, isStall, utlbReq, writeShadow, itlbMissExc, itlbMultiHit;
    logic [1:0]  itlbHitIdx, writeIdx;
    logic [21:0] utlbReqEA;

    int n_vec = 0, n_err = 0;

    p405s_itlb_miss_ctl dut (
        .CB(CB), .Reset(Reset), .entryHit(entryHit), .isFetchVal(isFetchVal),
        .msrIrL2(msrIrL2), .isAbort(isAbort), .isEA(isEA), .utlbGnt(utlbGnt),
        .utlbAck(utlbAck), .utlbMiss(utlbMiss), .itlbHit(itlbHit),
        .itlbHitIdx(itlbHitIdx), .isStall(isStall), .utlbReq(utlbReq),
        .utlbReqEA(utlbReqEA), .writeShadow(writeShadow), .writeIdx(writeIdx),
        .itlbMissExc(itlbMissExc), .itlbMultiHit(itlbMultiHit)
    );

    always #5 CB = ~CB;

    typedef struct {
        logic [3:0] hit;
        logic       fv, ir, ab;
        logic       e_hit;
        logic [1:0] e_idx;
        logic       e_stall;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic miss_seq(input logic [3:0] hv, input logic [21:0] ea, input logic um,
                            input logic [1:0] exp_idx, input logic exp_mh);
        entryHit = hv; isFetchVal = 1'b1; msrIrL2 = 1'b1; isEA = ea;
        #1;
        chk("miss_stall", isStall, 1);
        tick();
        isFetchVal = 1'b0; entryHit = '0;
        chk("mh_pulse", itlbMultiHit, exp_mh);
        chk("req_n1", utlbReq, 1);
        chk("req_ea", utlbReqEA, ea);
        tick();
        utlbGnt = 1'b1;
        chk("req_hold", utlbReq, 1);
        chk("mh_clear", itlbMultiHit, 0);
        tick();
        utlbGnt = 1'b0;
        chk("wait_noreq", utlbReq, 0);
        chk("wait_stall", isStall, 1);
        tick();
        utlbAck = 1'b1; utlbMiss = um;
        tick();
        utlbAck = 1'b0; utlbMiss = 1'b0;
        chk("fill_ws", writeShadow, !um);
        chk("fill_exc", itlbMissExc, um);
        if (!um) chk("fill_idx", writeIdx, exp_idx);
        tick();
        chk("post_ws", writeShadow, 0);
        chk("post_exc", itlbMissExc, 0);
        chk("post_stall", isStall, 0);
        if (!um) begin
            entryHit = 4'b0001 << exp_idx; isFetchVal = 1'b1;
            #1;
            chk("retry_hit", itlbHit, 1);
            chk("retry_idx", itlbHitIdx, exp_idx);
            chk("retry_stall", isStall, 0);
            #1;
            isFetchVal = 1'b0; entryHit = '0;
        end
    endtask

    initial begin
        tbl[0] = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[2] = '{4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
        tbl[3] = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[6] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[8] = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};

        #3;
        chk("rst_req", utlbReq, 0);
        chk("rst_ws", writeShadow, 0);
        chk("rst_exc", itlbMissExc, 0);
        chk("rst_ea", utlbReqEA, 0);
        chk("rst_widx", writeIdx, 0);
        chk("rst_mh", itlbMultiHit, 0);
        repeat (2) @(posedge CB);
        @(negedge CB);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge CB);
            entryHit = tbl[i].hit; isFetchVal = tbl[i].fv; msrIrL2 = tbl[i].ir; isAbort = tbl[i].ab;
            #1;
            chk($sformatf("tbl%0d_hit", i), itlbHit, tbl[i].e_hit);
            chk($sformatf("tbl%0d_stall", i), isStall, tbl[i].e_stall);
            if (tbl[i].e_hit) chk($sformatf("tbl%0d_idx", i), itlbHitIdx, tbl[i].e_idx);
            chk($sformatf("tbl%0d_req", i), utlbReq, 0);
            #1;
            isFetchVal = 1'b0; msrIrL2 = 1'b1; isAbort = 1'b0; entryHit = '0;
        end
        tick();

        miss_seq(4'b0000, 22'h0ABCD, 1'b0, 2'd0, 1'b0);
        miss_seq(4'b0000, 22'h01111, 1'b0, 2'd1, 1'b0);
        miss_seq(4'b0000, 22'h02222, 1'b1, 2'd2, 1'b0);
        miss_seq(4'b0000, 22'h03333, 1'b0, 2'd2, 1'b0);
        miss_seq(4'b0000, 22'h04444, 1'b0, 2'd3, 1'b0);
        miss_seq(4'b0000, 22'h3FFFF, 1'b0, 2'd0, 1'b0);

        // abort while requesting
        entryHit = '0; isFetchVal = 1'b1; isEA = 22'h05555;
        tick();
        isFetchVal = 1'b0;
        chk("abr_req_on", utlbReq, 1);
        isAbort = 1'b1;
        tick();
        chk("abr_req_off", utlbReq, 0);
        chk("abr_req_stall", isStall, 0);
        isAbort = 1'b0;
        tick();
        chk("abr_req_ws", writeShadow, 0);

        // abort while waiting, response arrives later
        isFetchVal = 1'b1;
        tick();
        isFetchVal = 1'b0; utlbGnt = 1'b1;
        tick();
        utlbGnt = 1'b0; isAbort = 1'b1;
        tick();
        isAbort = 1'b0;
        chk("abw_stall", isStall, 1);
        tick();
        utlbAck = 1'b1;
        tick();
        utlbAck = 1'b0;
        chk("abw_ws", writeShadow, 0);
        chk("abw_exc", itlbMissExc, 0);
        chk("abw_idle", isStall, 0);
        tick();
        chk("abw_ws2", writeShadow, 0);
        chk("abw_exc2", itlbMissExc, 0);

        // async reset in WAIT
        isFetchVal = 1'b1; isEA = 22'h12345;
        tick();
        isFetchVal = 1'b0; utlbGnt = 1'b1;
        tick();
        utlbGnt = 1'b0;
        chk("rw_stall_pre", isStall, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("rw_req", utlbReq, 0);
        chk("rw_stall", isStall, 0);
        chk("rw_ws", writeShadow, 0);
        chk("rw_ea", utlbReqEA, 0);
        tick();
        Reset = 1'b0;
        tick();
        utlbAck = 1'b1;
        tick();
        utlbAck = 1'b0;
        chk("rw_late_ws", writeShadow, 0);
        chk("rw_late_exc", itlbMissExc, 0);
        tick();
        chk("rw_late_ws2", writeShadow, 0);
        miss_seq(4'b0000, 22'h2AAAA, 1'b0, 2'd0, 1'b0);

`ifdef P405S_ITLB_MULTIHIT_DET_EN
        miss_seq(4'b1010, 22'h00777, 1'b0, 2'd1, 1'b1);
        miss_seq(4'b0000, 22'h00888, 1'b0, 2'd1, 1'b0);
`else
        entryHit = 4'b1010; isFetchVal = 1'b1;
        #1;
        chk("mh_off_hit", itlbHit, 1);
        chk("mh_off_idx", itlbHitIdx, 1);
        chk("mh_off_stall", isStall, 0);
        tick();
        entryHit = '0; isFetchVal = 1'b0;
        chk("mh_off_pulse", itlbMultiHit, 0);
        chk("mh_off_req", utlbReq, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
